// File: rtl/rr_arbiter_pkg.sv
// Shared types for the round-robin arbiter.
// Holds the two-state FSM encoding.
package rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_prio_enc.sv
// Rotating priority encoder.
// Picks the first set request at or above ptr, wrapping at N-1.
module rr_prio_enc #(
    parameter int CTRL = 2,
    localparam int N = 2 ** CTRL
) (
    input  logic [N-1:0]    req,
    input  logic [CTRL-1:0] ptr,
    output logic [CTRL-1:0] win,
    output logic            any
);

    logic [CTRL-1:0] idx;

    // Scan from the farthest offset down so the nearest hit wins.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr + CTRL'(i);
            if (req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter granting one requester at a time.
// A grant is held until done, then one idle cycle precedes the next.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int CTRL       = 2,
    parameter int DATA_WIDTH = 1,
    localparam int N = 2 ** CTRL
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req [N],
    input  logic [DATA_WIDTH-1:0] req_data [N],
    input  logic                  done,
    output logic                  grant_valid,
    output logic [CTRL-1:0]       grant_idx,
    output logic [N-1:0]          grant_onehot,
    output logic [DATA_WIDTH-1:0] out_data
);

    state_t          state;
    state_t          state_nx;
    logic [CTRL-1:0] ptr;
    logic [CTRL-1:0] ptr_nx;
    logic [CTRL-1:0] gidx;
    logic [CTRL-1:0] gidx_nx;
    logic [N-1:0]    reqv;
    logic [CTRL-1:0] win;
    logic            any;

    always_comb begin
        reqv = '0;
        for (int i = 0; i < N; i++) begin
            reqv[i] = req[i];
        end
    end

    rr_prio_enc #(
        .CTRL (CTRL)
    ) u_enc (
        .req (reqv),
        .ptr (ptr),
        .win (win),
        .any (any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            gidx  <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            gidx  <= gidx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        gidx_nx  = gidx;
        unique case (state)
            IDLE: begin
                if (any) begin
                    state_nx = BUSY;
                    gidx_nx  = win;
                end
            end
            BUSY: begin
                // Pointer advances past the winner with natural wrap.
                if (done) begin
                    state_nx = IDLE;
                    ptr_nx   = gidx + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        out_data     = '0;
        if (state == BUSY) begin
            grant_valid       = 1'b1;
            grant_idx         = gidx;
            grant_onehot[gidx] = 1'b1;
            out_data          = req_data[gidx];
        end
    end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter (CTRL=2, DATA_WIDTH=8).
// Stimulus queues expected grants; a monitor checks each new grant.
module tb_rr_arbiter;

    localparam int CTRL = 2;
    localparam int DW   = 8;
    localparam int N    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req [N];
    logic [DW-1:0] req_data [N];
    logic          done;
    logic          grant_valid;
    logic [CTRL-1:0] grant_idx;
    logic [N-1:0]  grant_onehot;
    logic [DW-1:0] out_data;

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] dtab [N];
    logic [CTRL-1:0] expq [$];
    logic prev_valid = 1'b0;

    rr_arbiter #(
        .CTRL       (CTRL),
        .DATA_WIDTH (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .done         (done),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .out_data     (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setreq(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) req[i] = v[i];
    endtask

    // Monitor: each rising grant_valid consumes one expected grant.
    always @(negedge clk) begin
        if (grant_valid && !prev_valid) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_grant: got idx %0d expected none",
                         grant_idx);
            end else begin
                logic [CTRL-1:0] e;
                logic [N-1:0] oh;
                e = expq.pop_front();
                oh = '0;
                oh[e] = 1'b1;
                chk("grant_idx", int'(grant_idx), int'(e));
                chk("grant_onehot", int'(grant_onehot), int'(oh));
                chk("grant_data", int'(out_data), int'(dtab[e]));
            end
        end
        prev_valid = grant_valid;
    end

    initial begin
        dtab[0] = 8'h10;
        dtab[1] = 8'hA5;
        dtab[2] = 8'h32;
        dtab[3] = 8'h43;
        for (int i = 0; i < N; i++) req_data[i] = dtab[i];
        reset = 1'b1;
        done  = 1'b0;
        setreq(4'b0000);
        cyc();
        cyc();
        chk("rst_valid", int'(grant_valid), 0);
        chk("rst_idx", int'(grant_idx), 0);
        chk("rst_onehot", int'(grant_onehot), 0);
        chk("rst_data", int'(out_data), 0);

        // Basic grant from ptr 0, then pointer moves past winner.
        reset = 1'b0;
        setreq(4'b1010);
        expq.push_back(2'd1);
        cyc();
        chk("latency_valid", int'(grant_valid), 1);
        chk("busy_data_a5", int'(out_data), 8'hA5);
        done = 1'b1;
        setreq(4'b1000);
        expq.push_back(2'd3);
        cyc();
        done = 1'b0;
        chk("release_valid", int'(grant_valid), 0);
        chk("release_data", int'(out_data), 0);
        chk("release_onehot", int'(grant_onehot), 0);
        cyc();

        // Wrap from 3 to 0, then from 0 on to 3.
        done = 1'b1;
        setreq(4'b1001);
        expq.push_back(2'd0);
        cyc();
        done = 1'b0;
        cyc();
        done = 1'b1;
        expq.push_back(2'd3);
        cyc();
        done = 1'b0;
        cyc();
        done = 1'b1;
        setreq(4'b0000);
        cyc();
        done = 1'b0;

        // All requesting: 0,1,2,3,0 with an idle cycle between grants.
        setreq(4'b1111);
        for (int k = 0; k < 5; k++) begin
            logic [CTRL-1:0] e;
            e = CTRL'(k % N);
            expq.push_back(e);
            cyc();
            chk("rr_busy", int'(grant_valid), 1);
            done = 1'b1;
            if (k == 4) setreq(4'b0000);
            cyc();
            done = 1'b0;
            chk("rr_idle_gap", int'(grant_valid), 0);
        end

        // ptr is now 1: grant 2, then hold against req changes.
        setreq(4'b0100);
        expq.push_back(2'd2);
        cyc();
        setreq(4'b0001);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("hold_valid", int'(grant_valid), 1);
            chk("hold_idx", int'(grant_idx), 2);
        end
        done = 1'b1;
        setreq(4'b0000);
        cyc();
        done = 1'b0;

        // ptr is now 3: grant 3, then reset mid-grant.
        setreq(4'b1000);
        expq.push_back(2'd3);
        cyc();
        setreq(4'b0000);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midrst_valid", int'(grant_valid), 0);
        chk("midrst_idx", int'(grant_idx), 0);
        done = 1'b1;
        cyc();
        done = 1'b0;
        cyc();
        chk("idle_done_valid", int'(grant_valid), 0);
        setreq(4'b1111);
        expq.push_back(2'd0);
        cyc();
        done = 1'b1;
        setreq(4'b0000);
        cyc();
        done = 1'b0;
        cyc();
        cyc();

        chk("pending_grants", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
